// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-stage bus of the load/store access controller.
// The master side is the ALU requester plus the memory stage's data-out.
interface mem_access_ctrl_if;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        misalign;
   logic        mem_wren;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, mem_dout,
      input  req_ready, resp_valid, resp_rdata, misalign, mem_wren, mem_addr, mem_din
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, mem_dout,
      output req_ready, resp_valid, resp_rdata, misalign, mem_wren, mem_addr, mem_din
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequential lw/sw/lb/sb controller in front of a word-addressed, one-cycle-read RAM.
// sb is done as read-modify-write since the RAM has no byte enables.
module mem_access_ctrl #(
   parameter bit ZERO_EXT_LB = 1'b1
) (
   input logic clk,
   input logic reset,
   mem_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

   localparam logic [1:0] OP_LW = 2'b00;
   localparam logic [1:0] OP_SW = 2'b01;
   localparam logic [1:0] OP_LB = 2'b10;
   localparam logic [1:0] OP_SB = 2'b11;

   state_t      state;
   logic [1:0]  opReg;
   logic [1:0]  lane;
   logic [7:0]  byteWdata;
   logic [7:0]  laneByte;
   logic [31:0] loadResult;
   logic [31:0] mergedWord;

   // Little-endian lane select on the word returned in CAP.
   always_comb begin
      laneByte   = bus.mem_dout[{lane, 3'b000} +: 8];
      mergedWord = bus.mem_dout;
      mergedWord[{lane, 3'b000} +: 8] = byteWdata;
      if (opReg == OP_LB)
         loadResult = {(ZERO_EXT_LB ? 24'h0 : {24{laneByte[7]}}), laneByte};
      else
         loadResult = bus.mem_dout;
   end

   assign bus.req_ready = (state == IDLE);
   // Gated by reset so a reset landing in WR never reaches the RAM.
   assign bus.mem_wren  = (state == WR) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         opReg          <= OP_LW;
         lane           <= 2'b00;
         byteWdata      <= 8'h00;
         bus.resp_valid <= 1'b0;
         bus.misalign   <= 1'b0;
         bus.resp_rdata <= 32'h0;
         bus.mem_addr   <= 32'h0;
         bus.mem_din    <= 32'h0;
      end else begin
         bus.resp_valid <= 1'b0;
         bus.misalign   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  opReg        <= bus.req_op;
                  lane         <= bus.req_addr[1:0];
                  byteWdata    <= bus.req_wdata[7:0];
                  bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
                  if (bus.req_op == OP_SW) begin
                     bus.mem_din <= bus.req_wdata;
                     state       <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD:  state <= CAP;
            CAP: begin
               if (opReg == OP_SB) begin
                  bus.mem_din <= mergedWord;
                  state       <= WR;
               end else begin
                  bus.resp_rdata <= loadResult;
                  bus.resp_valid <= 1'b1;
                  bus.misalign   <= (opReg == OP_LW) && (lane != 2'b00);
                  state          <= IDLE;
               end
            end
            WR: begin
               bus.resp_valid <= 1'b1;
               bus.misalign   <= (opReg == OP_SW) && (lane != 2'b00);
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
